modinv_euclid: RTL and testbench

- Parametrised successor to the brute-force private-key generator: computes d = e^-1 mod totient with the iterative extended Euclidean algorithm.
- Replaces the linear trial search with O(log totient) iterations, a start/busy/done handshake and a non-invertible error flag.
- Sits between public-exponent selection and the decrypt datapath; d is held stable for the modexp core.

---
 rtl/modinv_euclid_pkg.sv | 33 +++
 rtl/modinv_euclid_seq_div.sv | 104 ++++++++++
 rtl/modinv_euclid.sv | 188 ++++++++++++++++++
 tb/tb_modinv_euclid.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/modinv_euclid_pkg.sv
// -----------------------------------------------------------------------------
// modinv_pkg
//   Shared types and sizing helpers for the modular-inverse block
//   (modinv_euclid) and its sequential divider (modinv_seq_div).
//   Contents:
//     state_t  - controller state encoding
//     cnt_w()  - divider step-counter width for a given operand width. The
//                counter has to reach 2*WIDTH when the self-check divider is
//                built (macro MODINV_SELF_CHECK_EN).
//     CNT_W    - cnt_w() evaluated at the default operand width
// -----------------------------------------------------------------------------
package modinv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      DIV_LAUNCH,
      DIV_WAIT,
      UPDATE,
      FIXUP,
      VERIFY,
      DONE
   } state_t;

   localparam int WIDTH_DEFAULT = 12;

   function automatic int cnt_w(input int width);
      return $clog2(2 * width + 1);
   endfunction

   localparam int CNT_W = cnt_w(WIDTH_DEFAULT);

endpackage

// File: rtl/modinv_euclid_seq_div.sv
// -----------------------------------------------------------------------------
// modinv_seq_div
//   Restoring divider. It produces one quotient bit per clock and registers
//   both the quotient and the remainder.
//   The first quotient bit is produced on the start edge. An N-step division
//   therefore pulses done N-1 cycles after start, and the caller sees that
//   pulse in the N-th cycle after launch.
//   With short_op high, only the low DV bits of the dividend are divided
//   (DV steps). With short_op low, the full DW-bit dividend is divided
//   (DW steps).
//   Ports:
//     clk, rst   clock, asynchronous active-low reset
//     start      one-cycle launch. The divisor must be non-zero.
//     short_op   select the DV-step short division
//     dividend   DW-bit dividend
//     divisor    DV-bit divisor
//     done       one-cycle pulse when quotient and remainder are valid
//     quotient   low DV bits of the quotient
//     remainder  DV-bit remainder
// -----------------------------------------------------------------------------
module modinv_seq_div
   import modinv_pkg::*;
#(
   parameter int DW = 12,
   parameter int DV = 12,
   parameter int CW = cnt_w(DV)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          short_op,
   input  logic [DW-1:0] dividend,
   input  logic [DV-1:0] divisor,
   output logic          done,
   output logic [DV-1:0] quotient,
   output logic [DV-1:0] remainder
);

   logic [DW-1:0] acc_reg;   // unconsumed dividend bits in the top, quotient bits shifting in at the bottom
   logic [DV-1:0] rem_reg;
   logic [CW-1:0] cnt_reg;
   logic          run_reg;
   logic          done_reg;

   logic [DW-1:0] load_acc;
   logic [CW-1:0] load_steps;
   logic [DV-1:0] step_rem_in;
   logic [DW-1:0] step_acc_in;
   logic [DV-1:0] step_rem;
   logic [DW-1:0] step_acc;

   // One restoring step. When part >= dv, the difference is smaller than dv,
   // so a DV-bit subtraction is exact.
   function automatic logic [DV+DW-1:0] div_step(input logic [DV-1:0] r,
                                                 input logic [DW-1:0] a,
                                                 input logic [DV-1:0] dv);
      logic [DV:0] part;
      part = {r, a[DW-1]};
      if (part >= {1'b0, dv})
         return {part[DV-1:0] - dv, a[DW-2:0], 1'b1};
      else
         return {part[DV-1:0], a[DW-2:0], 1'b0};
   endfunction

   // A short division left-aligns the low DV bits of the dividend. The
   // quotient then finishes in the low DV bits of acc_reg.
   assign load_acc   = short_op ? (dividend << (DW - DV)) : dividend;
   assign load_steps = short_op ? CW'(DV) : CW'(DW);

   assign step_rem_in = start ? '0 : rem_reg;
   assign step_acc_in = start ? load_acc : acc_reg;
   assign {step_rem, step_acc} = div_step(step_rem_in, step_acc_in, divisor);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_reg  <= '0;
         rem_reg  <= '0;
         cnt_reg  <= '0;
         run_reg  <= 1'b0;
         done_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (start) begin
            acc_reg <= step_acc;
            rem_reg <= step_rem;
            cnt_reg <= load_steps - CW'(1);
            run_reg <= 1'b1;
         end else if (run_reg) begin
            acc_reg <= step_acc;
            rem_reg <= step_rem;
            cnt_reg <= cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) begin
               run_reg  <= 1'b0;
               done_reg <= 1'b1;
            end
         end
      end
   end

   assign done      = done_reg;
   assign quotient  = acc_reg[DV-1:0];
   assign remainder = rem_reg;

endmodule

// File: rtl/modinv_euclid.sv
// -----------------------------------------------------------------------------
// modinv_euclid
//   Computes d = e^-1 mod totient with the iterative extended Euclidean
//   algorithm. A sequential divider produces each quotient and remainder.
//   The result is held stable until the next accepted start.
//   Optional macro MODINV_SELF_CHECK_EN: after a successful FIXUP, a VERIFY
//   pass reuses a 2*WIDTH-bit divider to check that e*d mod totient == 1.
//   Ports:
//     clk, rst   clock, asynchronous active-low reset
//     start      request. It is accepted in IDLE, or in DONE once the done
//                pulse has passed.
//     e, totient operands, captured on an accepted start
//     busy       high while a computation runs
//     done       one-cycle pulse when d/error are valid
//     error      no inverse exists. Held until the next accepted start.
//     d          inverse in [1, totient-1], or 0 on error
// -----------------------------------------------------------------------------
module modinv_euclid
   import modinv_pkg::*;
#(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] e,
   input  logic [WIDTH-1:0] totient,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [WIDTH-1:0] d
);

`ifdef MODINV_SELF_CHECK_EN
   localparam int DIV_W = 2 * WIDTH;
`else
   localparam int DIV_W = WIDTH;
`endif
   localparam int CW = cnt_w(WIDTH);

   state_t                  state_reg;
   logic [WIDTH-1:0]        e_reg, tot_reg, r0_reg, r1_reg, d_reg;
   logic signed [WIDTH:0]   t0_reg, t1_reg;
   logic                    busy_reg, done_reg, error_reg, err_reg;

   logic                    div_start, div_short, div_done;
   logic [DIV_W-1:0]        div_dividend;
   logic [WIDTH-1:0]        div_q, div_rem;
   logic signed [WIDTH:0]   t_next;
   logic [WIDTH-1:0]        d_fix;

`ifdef MODINV_SELF_CHECK_EN
   logic                    vfirst_reg;
   logic [2*WIDTH-1:0]      ed_prod;
   assign ed_prod      = {{WIDTH{1'b0}}, e_reg} * {{WIDTH{1'b0}}, d_reg};
   assign div_start    = (state_reg == DIV_LAUNCH) || (state_reg == VERIFY && vfirst_reg);
   assign div_short    = (state_reg != VERIFY);
   assign div_dividend = div_short ? {{WIDTH{1'b0}}, r0_reg} : ed_prod;
`else
   assign div_start    = (state_reg == DIV_LAUNCH);
   assign div_short    = 1'b1;
   assign div_dividend = r0_reg;
`endif

   modinv_seq_div #(
      .DW (DIV_W),
      .DV (WIDTH),
      .CW (CW)
   ) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .short_op  (div_short),
      .dividend  (div_dividend),
      .divisor   (r1_reg),
      .done      (div_done),
      .quotient  (div_q),
      .remainder (div_rem)
   );

   // t0 - q*t1. The low WIDTH+1 bits of a product depend only on the low
   // WIDTH+1 bits of its operands. Since |t| <= totient, computing this
   // directly at WIDTH+1 bits gives the same result as a full 2*WIDTH+1
   // product followed by truncation.
   assign t_next = t0_reg - ($signed({1'b0, div_q}) * t1_reg);

   // Map a negative Bezout coefficient into [0, totient).
   assign d_fix = t0_reg[WIDTH-1:0] + (t0_reg[WIDTH] ? tot_reg : '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         e_reg     <= '0;
         tot_reg   <= '0;
         r0_reg    <= '0;
         r1_reg    <= '0;
         t0_reg    <= '0;
         t1_reg    <= '0;
         d_reg     <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         error_reg <= 1'b0;
         err_reg   <= 1'b0;
`ifdef MODINV_SELF_CHECK_EN
         vfirst_reg <= 1'b0;
`endif
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE, DONE: begin
               // Gating on done_reg drops a start that coincides with the done pulse.
               if (start && !done_reg) begin
                  e_reg     <= e;
                  tot_reg   <= totient;
                  busy_reg  <= 1'b1;
                  error_reg <= 1'b0;
                  err_reg   <= 1'b0;
                  d_reg     <= '0;
                  state_reg <= INIT;
               end
            end
            INIT: begin
               r0_reg <= tot_reg;
               r1_reg <= e_reg;
               t0_reg <= '0;
               t1_reg <= (WIDTH+1)'(1);
               if (tot_reg < WIDTH'(2)) begin
                  err_reg   <= 1'b1;
                  state_reg <= FIXUP;
               end else if (e_reg == '0) begin
                  state_reg <= FIXUP;
               end else begin
                  state_reg <= DIV_LAUNCH;
               end
            end
            DIV_LAUNCH: state_reg <= DIV_WAIT;
            DIV_WAIT: if (div_done) state_reg <= UPDATE;
            UPDATE: begin
               r0_reg    <= r1_reg;
               r1_reg    <= div_rem;
               t0_reg    <= t1_reg;
               t1_reg    <= t_next;
               state_reg <= (div_rem == '0) ? FIXUP : DIV_LAUNCH;
            end
            FIXUP: begin
               if (err_reg || r0_reg != WIDTH'(1)) begin
                  d_reg     <= '0;
                  error_reg <= 1'b1;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  d_reg <= d_fix;
`ifdef MODINV_SELF_CHECK_EN
                  vfirst_reg <= 1'b1;
                  state_reg  <= VERIFY;
`else
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
`endif
               end
            end
`ifdef MODINV_SELF_CHECK_EN
            VERIFY: begin
               vfirst_reg <= 1'b0;
               if (div_done) begin
                  if (div_rem != WIDTH'(1)) begin
                     error_reg <= 1'b1;
                     d_reg     <= '0;
                  end
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end
            end
`endif
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign busy  = busy_reg;
   assign done  = done_reg;
   assign error = error_reg;
   assign d     = d_reg;

endmodule

// File: tb/tb_modinv_euclid.sv
`timescale 1ns/1ps
module tb_modinv_euclid;

   localparam int W = 12;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] e = '0;
   logic [W-1:0] totient = '0;
   logic         busy, done, error;
   logic [W-1:0] d;

   always #5 clk = ~clk;

   modinv_euclid #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .e       (e),
      .totient (totient),
      .busy    (busy),
      .done    (done),
      .error   (error),
      .d       (d)
   );

   typedef struct {
      int    exp_d;
      int    exp_err;
      int    exp_lat;
      int    t_start;
      string tag;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int expv);
      n_vec++;
      if (act != expv) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   // Cycles from the start-sampling edge to done.
   function automatic int lat(input int n, input bit err);
      int l;
      l = 2 + n * (W + 2);
`ifdef MODINV_SELF_CHECK_EN
      if (!err) l += 1 + 2 * W;
`endif
      return l;
   endfunction

   // Monitor: every done pulse must match the oldest expected result.
   exp_t mx;
   always @(negedge clk) begin
      if (rst && done) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL spurious_done: got done=1 at cycle %0d, expected no result pending", cyc);
         end else begin
            mx = sb.pop_front();
            $display("txn %s: d=%0d error=%0d latency=%0d", mx.tag, d, error, cyc - mx.t_start - 1);
            chk({mx.tag, " d"}, int'(d), mx.exp_d);
            chk({mx.tag, " error"}, int'(error), mx.exp_err);
            chk({mx.tag, " latency"}, cyc - mx.t_start - 1, mx.exp_lat);
         end
      end
   end

   task automatic push_exp(input string tag, input int ed, input bit eerr, input int n);
      exp_t x;
      x.exp_d   = ed;
      x.exp_err = int'(eerr);
      x.exp_lat = lat(n, eerr);
      x.t_start = cyc;
      x.tag     = tag;
      sb.push_back(x);
   endtask

   task automatic wait_empty(input string tag);
      int i;
      i = 0;
      while (sb.size() != 0 && i < 1000) begin
         @(negedge clk);
         i++;
      end
      if (sb.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s timeout: no done within 1000 cycles, expected done", tag);
         sb.delete();
      end
   endtask

   task automatic run(input string tag, input int ev, input int tv, input int ed,
                      input bit eerr, input int n, input int glitch);
      @(negedge clk);
      e       = W'(ev);
      totient = W'(tv);
      start   = 1'b1;
      push_exp(tag, ed, eerr, n);
      @(negedge clk);
      start   = 1'b0;
      e       = W'($urandom);
      totient = W'($urandom);
      chk({tag, " busy"}, int'(busy), 1);
      if (glitch > 0) begin
         repeat (glitch - 1) @(negedge clk);
         e       = W'(3);
         totient = W'(20);
         start   = 1'b1;
         @(negedge clk);
         start   = 1'b0;
      end
      wait_empty(tag);
   endtask

   initial begin
      int i;
      repeat (3) @(negedge clk);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset error", int'(error), 0);
      chk("reset d", int'(d), 0);
      rst = 1'b1;

      // Main vector with a start pulse ignored mid-run
      run("e17_t3120", 17, 3120, 2753, 1'b0, 4, 10);
      repeat (5) @(negedge clk);
      chk("e17 d hold", int'(d), 2753);
      chk("e17 error hold", int'(error), 0);

      run("e3_t20",  3,  20, 7, 1'b0, 3, 0);
      run("e4_t20",  4,  20, 0, 1'b1, 1, 0);
      run("e0_t20",  0,  20, 0, 1'b1, 0, 0);
      run("e1_t1",   1,   1, 0, 1'b1, 0, 0);
      run("e25_t20", 25, 20, 0, 1'b1, 3, 0);
      run("e1_t20",  1,  20, 1, 1'b0, 1, 0);

      // A start coinciding with the done pulse must be dropped
      @(negedge clk);
      e = W'(3); totient = W'(20); start = 1'b1;
      push_exp("done_coincide", 7, 1'b0, 3);
      @(negedge clk);
      start = 1'b0;
      i = 0;
      while (!done && i < 200) begin
         @(negedge clk);
         i++;
      end
      chk("done_coincide done seen", int'(done), 1);
      e = W'(17); totient = W'(3120); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start on done ignored busy", int'(busy), 0);
      repeat (3) @(negedge clk);
      chk("start on done ignored d", int'(d), 7);
      run("after_done", 17, 3120, 2753, 1'b0, 4, 0);

      // Asynchronous reset in the middle of a run
      @(negedge clk);
      e = W'(17); totient = W'(3120); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      chk("pre-reset busy", int'(busy), 1);
      #2 rst = 1'b0;
      #1;
      chk("async reset busy", int'(busy), 0);
      chk("async reset done", int'(done), 0);
      chk("async reset d", int'(d), 0);
      chk("async reset error", int'(error), 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      chk("aborted run stays idle busy", int'(busy), 0);
      run("post_reset", 3, 20, 7, 1'b0, 3, 0);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
